// File: rtl/rb_deriv_normalizer.sv
// Accumulates up to NUM_TERMS weighted R/B derivatives per pixel and divides by the weight sum.
// Optional macro RB_NORM_ROUND_EN: round half away from zero instead of truncating.
module rb_deriv_normalizer #(
  parameter int unsigned NUM_TERMS = 4,
  parameter int unsigned DERIV_W   = 22,
  parameter int unsigned GRAD_W    = 8,
  parameter int unsigned OUT_W     = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [GRAD_W-1:0]         grad,
  input  logic signed [DERIV_W-1:0] RB_deriv,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   G_m_RB_est,
  output logic                      div_zero
);

  localparam int unsigned CNT_W  = $clog2(NUM_TERMS);
  localparam int unsigned SUM_W  = DERIV_W + CNT_W;
  localparam int unsigned WSUM_W = GRAD_W + CNT_W;
  localparam int unsigned MAG_W  = SUM_W + 1;
  localparam int unsigned DCNT_W = $clog2(SUM_W + 1);
  localparam logic [MAG_W-1:0] POS_LIM = MAG_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(64'd1 << (OUT_W - 1));

  typedef enum logic [1:0] {ST_ACC, ST_DIV, ST_OUT} state_t;

  state_t              state, state_nxt;
  logic [SUM_W-1:0]    dsum;
  logic [WSUM_W-1:0]   wsum;
  logic [CNT_W-1:0]    term_cnt;
  logic [DCNT_W-1:0]   div_cnt;
  logic [SUM_W-1:0]    quo;
  logic [WSUM_W-1:0]   rem;
  logic                neg;

  logic                acc_en, div_load, div_step, fin, zero_res, out_done;
  logic                accept, last_beat;
  logic [SUM_W-1:0]    dsum_acc, dsum_mag, quo_step;
  logic [WSUM_W-1:0]   wsum_acc, rem_step;
  logic [WSUM_W:0]     trial;
  logic                ge, round_up;
  logic [MAG_W-1:0]    mag_c;
  logic [OUT_W-1:0]    est_c;

  // Accumulate path; the NUM_TERMS-th beat closes the group even without in_last
  assign accept    = in_valid & in_ready;
  assign last_beat = in_last | (term_cnt == CNT_W'(NUM_TERMS - 1));
  assign dsum_acc  = dsum + {{CNT_W{RB_deriv[DERIV_W-1]}}, RB_deriv};
  assign wsum_acc  = wsum + WSUM_W'(grad);
  assign dsum_mag  = dsum[SUM_W-1] ? (~dsum + SUM_W'(1)) : dsum;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  assign trial    = {rem, quo[SUM_W-1]};
  assign ge       = trial >= {1'b0, wsum};
  assign rem_step = WSUM_W'(ge ? (trial - {1'b0, wsum}) : trial);
  assign quo_step = {quo[SUM_W-2:0], ge};

`ifdef RB_NORM_ROUND_EN
  assign round_up = {rem_step, 1'b0} >= {1'b0, wsum};
`else
  assign round_up = 1'b0;
`endif

  // Apply sign to the magnitude and clamp into the signed output range
  always_comb begin
    mag_c = {1'b0, quo_step} + MAG_W'(round_up);
    est_c = '0;
    if (neg) begin
      if (mag_c > NEG_LIM) est_c = {1'b1, {(OUT_W-1){1'b0}}};
      else                 est_c = OUT_W'(MAG_W'(0) - mag_c);
    end else begin
      if (mag_c > POS_LIM) est_c = {1'b0, {(OUT_W-1){1'b1}}};
      else                 est_c = OUT_W'(mag_c);
    end
  end

  // Next-state and datapath strobes; DIV spends one setup cycle then SUM_W step cycles
  always_comb begin
    state_nxt = state;
    acc_en    = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
    fin       = 1'b0;
    zero_res  = 1'b0;
    out_done  = 1'b0;
    case (state)
      ST_ACC: begin
        if (accept) begin
          acc_en = 1'b1;
          if (last_beat) state_nxt = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_cnt == '0) begin
          if (wsum == '0) begin
            zero_res  = 1'b1;
            state_nxt = ST_OUT;
          end else begin
            div_load = 1'b1;
          end
        end else begin
          div_step = 1'b1;
          if (div_cnt == DCNT_W'(SUM_W)) begin
            fin       = 1'b1;
            state_nxt = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_done  = 1'b1;
          state_nxt = ST_ACC;
        end
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ACC;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      G_m_RB_est <= '0;
      div_zero   <= 1'b0;
      dsum       <= '0;
      wsum       <= '0;
      term_cnt   <= '0;
      div_cnt    <= '0;
      quo        <= '0;
      rem        <= '0;
      neg        <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ST_ACC);
      out_valid <= (state_nxt == ST_OUT);
      if (acc_en) begin
        dsum     <= dsum_acc;
        wsum     <= wsum_acc;
        term_cnt <= term_cnt + CNT_W'(1);
        div_cnt  <= '0;
      end
      if (div_load) begin
        quo     <= dsum_mag;
        rem     <= '0;
        neg     <= dsum[SUM_W-1];
        div_cnt <= div_cnt + DCNT_W'(1);
      end
      if (div_step) begin
        quo     <= quo_step;
        rem     <= rem_step;
        div_cnt <= div_cnt + DCNT_W'(1);
      end
      if (fin) begin
        G_m_RB_est <= est_c;
        div_zero   <= 1'b0;
      end
      if (zero_res) begin
        G_m_RB_est <= '0;
        div_zero   <= 1'b1;
      end
      if (out_done) begin
        dsum     <= '0;
        wsum     <= '0;
        term_cnt <= '0;
        div_cnt  <= '0;
        quo      <= '0;
        rem      <= '0;
        neg      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rb_deriv_normalizer.sv
// Scoreboard bench for rb_deriv_normalizer: expected results queued per group, checked on output.
module tb_rb_deriv_normalizer;

  localparam int NUM_TERMS = 4;
  localparam int SUM_W     = 24;
  localparam longint OMAX  = 8191;
  localparam longint OMIN  = -8192;

  typedef struct {
    longint est;
    longint dz;
    longint lat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [7:0]         grad;
  logic signed [21:0] RB_deriv;
  logic               out_valid;
  logic               out_ready;
  logic signed [13:0] G_m_RB_est;
  logic               div_zero;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_errors = 0;
  longint m_dsum   = 0;
  longint m_wsum   = 0;
  int     m_cnt    = 0;

  always #5 clk = ~clk;

  rb_deriv_normalizer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .grad       (grad),
    .RB_deriv   (RB_deriv),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .G_m_RB_est (G_m_RB_est),
    .div_zero   (div_zero)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input longint ds, input longint ws);
    exp_t   e;
    longint mag, q, r;
    if (ws == 0) begin
      e.est = 0; e.dz = 1; e.lat = 1;
    end else begin
      mag = (ds < 0) ? -ds : ds;
      q   = mag / ws;
      r   = mag % ws;
`ifdef RB_NORM_ROUND_EN
      if (2 * r >= ws) q = q + 1;
`endif
      if (ds < 0) q = -q;
      if (q > OMAX) q = OMAX;
      if (q < OMIN) q = OMIN;
      e.est = q; e.dz = 0; e.lat = longint'(SUM_W + 1);
    end
    return e;
  endfunction

  // Drive one beat at negedge, hold it until accepted, update the reference sums
  task automatic send_beat(input int g, input int d, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    grad     = 8'(g);
    RB_deriv = 22'(d);
    in_last  = last;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", longint'(guard >= 100), 0);
    @(posedge clk);
    m_dsum += longint'(d);
    m_wsum += longint'(g);
    m_cnt++;
    if (last || m_cnt == NUM_TERMS) begin
      sb.push_back(model(m_dsum, m_wsum));
      m_dsum = 0; m_wsum = 0; m_cnt = 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called at the negedge after the final accept; measures latency and pops the scoreboard
  task automatic get_result(input string tag, input int hold);
    exp_t e;
    int   lat;
    lat = 0;
    check({tag, "_busy"}, longint'(in_ready), 0);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_sb"}, longint'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_valid"}, longint'(out_valid), 1);
      check({tag, "_lat"}, longint'(lat), e.lat);
      check({tag, "_est"}, longint'(G_m_RB_est), e.est);
      check({tag, "_dz"}, longint'(div_zero), e.dz);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold_valid"}, longint'(out_valid), 1);
        check({tag, "_hold_est"}, longint'(G_m_RB_est), e.est);
        check({tag, "_hold_ready"}, longint'(in_ready), 0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done_valid"}, longint'(out_valid), 0);
    check({tag, "_done_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    int   len, g, d;
    logic last;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; grad = '0; RB_deriv = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_est", longint'(G_m_RB_est), 0);
    check("rst_dz", longint'(div_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    // Full group, in_last implied on the 4th beat
    for (int b = 0; b < 4; b++) send_beat(10, 1000, 1'b0);
    get_result("full", 0);

    send_beat(5, -1500, 1'b0);
    send_beat(5, -1500, 1'b1);
    get_result("early", 0);

    send_beat(0, 77, 1'b1);
    get_result("zero", 0);

    send_beat(1, 2097151, 1'b1);
    get_result("sat_pos", 0);
    send_beat(1, -2097152, 1'b1);
    get_result("sat_neg", 0);

    send_beat(3, 5, 1'b1);
    get_result("rnd_pos", 0);
    send_beat(3, -5, 1'b1);
    get_result("rnd_neg", 0);

    // Output backpressure
    send_beat(4, 4001, 1'b0);
    send_beat(4, -3, 1'b1);
    get_result("bp", 10);

    // Reset ten cycles into the division discards the group
    send_beat(7, 7000, 1'b1);
    repeat (10) @(negedge clk);
    check("abort_busy", longint'(in_ready), 0);
    rst = 1'b1;
    #1;
    check("abort_in_ready", longint'(in_ready), 1);
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_est", longint'(G_m_RB_est), 0);
    check("abort_dz", longint'(div_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_output", longint'(seen), 0);
    send_beat(6, 600, 1'b0);
    send_beat(6, -1800, 1'b1);
    get_result("after_abort", 0);

    // Random groups; odd ones keep out_ready high before the result exists
    for (int gi = 0; gi < 8; gi++) begin
      len = int'($urandom_range(1, 4));
      for (int b = 0; b < len; b++) begin
        g    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
        d    = int'($urandom_range(0, 4194303)) - 2097152;
        last = (b == len - 1) && (len < 4 || $urandom_range(0, 1) == 1);
        send_beat(g, d, last);
      end
      out_ready = (gi % 2 == 1);
      get_result("rand", 0);
    end

    check("sb_drained", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rb_deriv_normalizer.md
Name: rb_deriv_normalizer

Overview:
Inverse of the equ_36 weighting stage. Consumes a stream of gradient-weighted R/B derivatives (RB_deriv = grad-weighted G_m_RB terms) plus their grad weights. Accumulates up to NUM_TERMS terms per pixel and divides the derivative sum by the weight sum with a multi-cycle restoring divider. The result is a normalized signed G-minus-R/B estimate, delivered through a valid/ready handshake to the interpolation stage.

Parameters:
NUM_TERMS, 4, maximum terms per pixel group (power of 2, >=2)
DERIV_W, 22, signed RB_deriv width
GRAD_W, 8, unsigned grad weight width
OUT_W, 14, signed output width (matches G_m_RB)
Derived localparams:
- SUM_W = DERIV_W + log2(NUM_TERMS) (24)
- WSUM_W = GRAD_W + log2(NUM_TERMS) (10)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_last  in  1  final beat of the current group
grad  in  GRAD_W  unsigned weight of this term
RB_deriv  in  DERIV_W  signed weighted derivative of this term
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
G_m_RB_est  out  OUT_W  signed normalized estimate
div_zero  out  1  weight sum was zero (qualified by out_valid)

Behaviour:
Reset values:
- State ACC; in_ready=1; out_valid=0; G_m_RB_est=0; div_zero=0.
- Accumulators, term counter and divider registers cleared.

Accept rule:
- A beat is accepted on an edge where in_valid & in_ready.
- dsum += sign-extended RB_deriv; wsum += zero-extended grad; count++.

States:
- ACC:
  - in_ready=1.
  - On an accepted beat with in_last=1 or count==NUM_TERMS-1, go to DIV; if the final wsum==0, go directly to OUT.
  - in_last is implied on the NUM_TERMS-th beat.
- DIV:
  - in_ready=0.
  - Restoring division |dsum| / wsum, one quotient bit per cycle, exactly SUM_W cycles.
  - Sign applied afterwards: negative iff dsum<0.
  - Quotient is truncated toward zero.
- OUT:
  - out_valid=1; in_ready=0; outputs held stable until the edge where out_ready=1.
  - On that edge: out_valid->0, accumulators cleared, go to ACC.

Latency:
- out_valid rises SUM_W+1 edges after the edge that accepts the final beat (25 at defaults).
- Zero-weight path: 1 edge.

Saturation:
- A signed quotient outside [-2^(OUT_W-1), 2^(OUT_W-1)-1] clamps to the nearest limit.

Zero weight:
- G_m_RB_est=0, div_zero=1.
- Otherwise div_zero=0.

Accumulator range:
- dsum/wsum widths make overflow impossible for NUM_TERMS beats.

Backpressure:
- No input is accepted outside ACC; the upstream must hold its beat.
- out_ready asserted while out_valid=0 has no effect.

Reset mid-operation:
- rst in DIV or OUT aborts immediately to reset values; the partial result is discarded and never emitted.

Optional Feature:
Macro RB_NORM_ROUND_EN.
- Defined: after the division, if 2*remainder >= wsum, the magnitude increments by 1 (round half away from zero) before sign and saturation. Adds no cycles.
- Undefined: truncation toward zero as above.

Test Plan:
- Full group: 4 beats of grad=10, RB_deriv=1000 -> out_valid 25 edges after the 4th accept; G_m_RB_est=100, div_zero=0.
- Early in_last: grad=5/RB_deriv=-1500, then grad=5/RB_deriv=-1500 with in_last=1 -> G_m_RB_est=-300.
- Zero weight: single beat grad=0, RB_deriv=77, in_last=1 -> out_valid after 1 edge; G_m_RB_est=0, div_zero=1.
- Saturation: grad=1, RB_deriv=2097151 with in_last=1 -> G_m_RB_est=8191; RB_deriv=-2097152 -> -8192.
- Rounding: grad=3, RB_deriv=5 with in_last=1 -> 1 without RB_NORM_ROUND_EN, 2 with it; RB_deriv=-5 -> -1 / -2.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in OUT -> outputs stable, in_ready=0; result pops on the out_ready edge.
  - Assert rst 10 cycles into DIV -> immediate reset values; no out_valid; the next group computes correctly.
